// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-rate enable, x/y counters, delayed sync/blank.
// Optional build macro VGA_FRAME_CNT_EN adds a 16-bit frame counter output.
`timescale 1ns/1ps

module vga_timing_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_DLY = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        pix_en,
    output logic        vga_clk,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic        sync_n,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [9:0]       hcnt_q, hcnt_d;
    logic [9:0]       vcnt_q, vcnt_d;
    logic             frame_start_q, frame_start_d;
    logic             pix_tc;
    logic             hs_i, vs_i, de_i;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]      frame_cnt_q, frame_cnt_d;
`endif

    assign pix_tc = (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d     = pix_tc ? '0 : div_cnt_q + 1'b1;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        frame_start_d = 1'b0;
        if (pix_tc) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d        = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcnt_d = vcnt_q + 10'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
`ifdef VGA_FRAME_CNT_EN
        frame_cnt_d = frame_start_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= '0;
`endif
        end else begin
            div_cnt_q     <= div_cnt_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_CNT_EN
            frame_cnt_q   <= frame_cnt_d;
`endif
        end
    end

    // Raw timing decoded from the current counters, before alignment delay.
    always_comb begin
        hs_i = !((hcnt_q >= HS_START) && (hcnt_q < HS_END));
        vs_i = !((vcnt_q >= VS_START) && (vcnt_q < VS_END));
        de_i = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    end

    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign hsync   = hs_i | rst;
            assign vsync   = vs_i | rst;
            assign blank_n = de_i & ~rst;
        end else begin : g_dly
            localparam logic [2:0] DLY_IDLE = 3'b110;
            logic [2:0] dly_q [SYNC_DLY];
            logic [2:0] dly_d [SYNC_DLY];

            always_comb begin
                dly_d[0] = {hs_i, vs_i, de_i};
                for (int i = 1; i < SYNC_DLY; i++) begin
                    dly_d[i] = dly_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < SYNC_DLY; i++) begin
                        dly_q[i] <= DLY_IDLE;
                    end
                end else begin
                    for (int i = 0; i < SYNC_DLY; i++) begin
                        dly_q[i] <= dly_d[i];
                    end
                end
            end

            assign {hsync, vsync, blank_n} = dly_q[SYNC_DLY-1];
        end
    endgenerate

    // With one clk per pixel the DAC clock is held high instead of using ~clk.
    generate
        if (CLK_DIV == 1) begin : g_vclk_one
            assign vga_clk = ~rst;
        end else begin : g_vclk_div
            localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
            assign vga_clk = (div_cnt_q >= DIV_HALF);
        end
    endgenerate

    assign pix_en      = pix_tc & ~rst;
    assign x           = hcnt_q;
    assign y           = vcnt_q;
    assign sync_n      = 1'b0;
    assign frame_start = frame_start_q;
`ifdef VGA_FRAME_CNT_EN
    assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: three configurations checked against an arithmetic raster model
// through a per-cycle scoreboard, plus a table of hand-computed probe points.
`timescale 1ns/1ps

module tb_vga_timing_ctrl;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        pix_en;
        logic        vga_clk;
        logic        hsync;
        logic        vsync;
        logic        blank_n;
        logic        sync_n;
        logic        frame_start;
        logic [15:0] frame_cnt;
    } outs_t;

    typedef struct {
        int         ph;
        int         t;
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
    } probe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;

    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic pe_a, vc_a, hs_a, vs_a, bn_a, sn_a, fs_a;
    logic pe_b, vc_b, hs_b, vs_b, bn_b, sn_b, fs_b;
    logic pe_c, vc_c, hs_c, vs_c, bn_c, sn_c, fs_c;
    logic [15:0] fc_a, fc_b, fc_c;
    outs_t act_a, act_b, act_c;

    int checks = 0;
    int errors = 0;
    int probe_hits = 0;
    outs_t  sb_q[$];
    probe_t probes[$];

    vga_timing_ctrl #(.CLK_DIV(2), .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
                      .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .SYNC_DLY(2)) u_dut_a (
        .clk(clk), .rst(rst_a), .x(x_a), .y(y_a), .pix_en(pe_a), .vga_clk(vc_a),
        .hsync(hs_a), .vsync(vs_a), .blank_n(bn_a), .sync_n(sn_a), .frame_start(fs_a)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    vga_timing_ctrl #(.CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
                      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_DLY(0)) u_dut_b (
        .clk(clk), .rst(rst_b), .x(x_b), .y(y_b), .pix_en(pe_b), .vga_clk(vc_b),
        .hsync(hs_b), .vsync(vs_b), .blank_n(bn_b), .sync_n(sn_b), .frame_start(fs_b)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    vga_timing_ctrl #(.CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(1),
                      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_DLY(3)) u_dut_c (
        .clk(clk), .rst(rst_c), .x(x_c), .y(y_c), .pix_en(pe_c), .vga_clk(vc_c),
        .hsync(hs_c), .vsync(vs_c), .blank_n(bn_c), .sync_n(sn_c), .frame_start(fs_c)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(fc_c)
`endif
    );

`ifndef VGA_FRAME_CNT_EN
    assign fc_a = 16'd0;
    assign fc_b = 16'd0;
    assign fc_c = 16'd0;
`endif

    assign act_a = {x_a, y_a, pe_a, vc_a, hs_a, vs_a, bn_a, sn_a, fs_a, fc_a};
    assign act_b = {x_b, y_b, pe_b, vc_b, hs_b, vs_b, bn_b, sn_b, fs_b, fc_b};
    assign act_c = {x_c, y_c, pe_c, vc_c, hs_c, vs_c, bn_c, sn_c, fs_c, fc_c};

    function automatic outs_t act_of(int sel);
        case (sel)
            0:       return act_a;
            1:       return act_b;
            default: return act_c;
        endcase
    endfunction

    // Expected outputs t cycles after reset release, from plain raster arithmetic.
    function automatic outs_t model(int sel, int t);
        outs_t o;
        int div, ha, hf, hw, hb, va, vf, vw, vb, dly;
        int ht, vt, fr, p, td, xd, yd;
        case (sel)
            0:       begin div = 2; ha = 640; hf = 16; hw = 96; hb = 48;
                           va = 480; vf = 10; vw = 2; vb = 33; dly = 2; end
            1:       begin div = 1; ha = 8; hf = 1; hw = 2; hb = 1;
                           va = 4; vf = 1; vw = 1; vb = 1; dly = 0; end
            default: begin div = 3; ha = 6; hf = 2; hw = 3; hb = 1;
                           va = 4; vf = 1; vw = 2; vb = 1; dly = 3; end
        endcase
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        fr = div * ht * vt;
        p  = t / div;
        o.x           = 10'(p % ht);
        o.y           = 10'((p / ht) % vt);
        o.pix_en      = ((t % div) == div - 1);
        o.vga_clk     = ((t % div) >= div / 2);
        o.sync_n      = 1'b0;
        o.frame_start = (t > 0) && ((t % fr) == 0);
`ifdef VGA_FRAME_CNT_EN
        o.frame_cnt   = 16'(t / fr);
`else
        o.frame_cnt   = 16'd0;
`endif
        td = t - dly;
        if (td < 0) begin
            o.hsync   = 1'b1;
            o.vsync   = 1'b1;
            o.blank_n = 1'b0;
        end else begin
            xd = (td / div) % ht;
            yd = ((td / div) / ht) % vt;
            o.hsync   = !((xd >= ha + hf) && (xd < ha + hf + hw));
            o.vsync   = !((yd >= va + vf) && (yd < va + vf + vw));
            o.blank_n = (xd < ha) && (yd < va);
        end
        return o;
    endfunction

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic check_outs(string name, int t, outs_t got, outs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got x=%0d y=%0d pe=%b vc=%b hs=%b vs=%b bn=%b sn=%b fs=%b fc=%0d exp x=%0d y=%0d pe=%b vc=%b hs=%b vs=%b bn=%b sn=%b fs=%b fc=%0d",
                     name, t, got.x, got.y, got.pix_en, got.vga_clk, got.hsync, got.vsync,
                     got.blank_n, got.sync_n, got.frame_start, got.frame_cnt,
                     exp.x, exp.y, exp.pix_en, exp.vga_clk, exp.hsync, exp.vsync,
                     exp.blank_n, exp.sync_n, exp.frame_start, exp.frame_cnt);
            if (errors >= 40) finish_run();
        end
    endtask

    task automatic do_reset(int sel);
        outs_t exp_rst;
        exp_rst = '{x: 10'd0, y: 10'd0, pix_en: 1'b0, vga_clk: 1'b0, hsync: 1'b1,
                    vsync: 1'b1, blank_n: 1'b0, sync_n: 1'b0, frame_start: 1'b0,
                    frame_cnt: 16'd0};
        case (sel)
            0:       rst_a = 1'b1;
            1:       rst_b = 1'b1;
            default: rst_c = 1'b1;
        endcase
        repeat (3) @(posedge clk);
        #1;
        check_outs($sformatf("reset_s%0d", sel), -1, act_of(sel), exp_rst);
        case (sel)
            0:       rst_a = 1'b0;
            1:       rst_b = 1'b0;
            default: rst_c = 1'b0;
        endcase
        sb_q.delete();
    endtask

    task automatic run_phase(int sel, int ph, int n);
        outs_t e, g;
        for (int t = 0; t < n; t++) begin
            sb_q.push_back(model(sel, t));
            @(negedge clk);
            e = sb_q.pop_front();
            g = act_of(sel);
            check_outs($sformatf("trace_s%0d_ph%0d", sel, ph), t, g, e);
            foreach (probes[i]) begin
                if (probes[i].ph == ph && probes[i].t == t) begin
                    probe_hits++;
                    checks++;
                    if ({g.x, g.y, g.hsync, g.vsync, g.blank_n, g.frame_start} !==
                        {probes[i].x, probes[i].y, probes[i].hs, probes[i].vs, probes[i].de, probes[i].fs}) begin
                        errors++;
                        $display("FAIL probe ph=%0d t=%0d got x=%0d y=%0d hs=%b vs=%b bn=%b fs=%b exp x=%0d y=%0d hs=%b vs=%b bn=%b fs=%b",
                                 ph, t, g.x, g.y, g.hsync, g.vsync, g.blank_n, g.frame_start,
                                 probes[i].x, probes[i].y, probes[i].hs, probes[i].vs,
                                 probes[i].de, probes[i].fs);
                        if (errors >= 40) finish_run();
                    end
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //                ph    t     x    y   hs  vs  de  fs
        probes.push_back('{0,    0,    0,   0,  1,  1,  0,  0});
        probes.push_back('{0,    1,    0,   0,  1,  1,  0,  0});
        probes.push_back('{0,    2,    1,   0,  1,  1,  1,  0});
        probes.push_back('{0, 1281,  640,   0,  1,  1,  1,  0});
        probes.push_back('{0, 1282,  641,   0,  1,  1,  0,  0});
        probes.push_back('{0, 1313,  656,   0,  1,  1,  0,  0});
        probes.push_back('{0, 1314,  657,   0,  0,  1,  0,  0});
        probes.push_back('{0, 1505,  752,   0,  0,  1,  0,  0});
        probes.push_back('{0, 1506,  753,   0,  1,  1,  0,  0});
        probes.push_back('{0, 1600,    0,   1,  1,  1,  0,  0});
        probes.push_back('{0, 1602,    1,   1,  1,  1,  1,  0});
        probes.push_back('{0, 2200,  300,   1,  1,  1,  1,  0});
        probes.push_back('{4,    0,    0,   0,  1,  1,  0,  0});
        probes.push_back('{4,    2,    1,   0,  1,  1,  1,  0});
        probes.push_back('{1,    0,    0,   0,  1,  1,  1,  0});
        probes.push_back('{1,    8,    8,   0,  1,  1,  0,  0});
        probes.push_back('{1,    9,    9,   0,  0,  1,  0,  0});
        probes.push_back('{1,   10,   10,   0,  0,  1,  0,  0});
        probes.push_back('{1,   11,   11,   0,  1,  1,  0,  0});
        probes.push_back('{1,   12,    0,   1,  1,  1,  1,  0});
        probes.push_back('{1,   48,    0,   4,  1,  1,  0,  0});
        probes.push_back('{1,   60,    0,   5,  1,  0,  0,  0});
        probes.push_back('{1,   71,   11,   5,  1,  0,  0,  0});
        probes.push_back('{1,   72,    0,   6,  1,  1,  0,  0});
        probes.push_back('{1,   83,   11,   6,  1,  1,  0,  0});
        probes.push_back('{1,   84,    0,   0,  1,  1,  1,  1});
        probes.push_back('{1,  149,    5,   5,  1,  0,  0,  0});
        probes.push_back('{3,    0,    0,   0,  1,  1,  1,  0});
        probes.push_back('{3,   83,   11,   6,  1,  1,  0,  0});
        probes.push_back('{3,   84,    0,   0,  1,  1,  1,  1});
        probes.push_back('{2,    2,    0,   0,  1,  1,  0,  0});
        probes.push_back('{2,    3,    1,   0,  1,  1,  1,  0});
        probes.push_back('{2,   26,    8,   0,  1,  1,  0,  0});
        probes.push_back('{2,   27,    9,   0,  0,  1,  0,  0});
        probes.push_back('{2,  182,    0,   5,  1,  1,  0,  0});
        probes.push_back('{2,  183,    1,   5,  1,  0,  0,  0});
        probes.push_back('{2,  254,    0,   7,  1,  0,  0,  0});
        probes.push_back('{2,  255,    1,   7,  1,  1,  0,  0});
        probes.push_back('{2,  288,    0,   0,  1,  1,  0,  1});
        probes.push_back('{2,  289,    0,   0,  1,  1,  0,  0});

        do_reset(0);
        run_phase(0, 0, 2201);
        do_reset(0);
        run_phase(0, 4, 40);

        do_reset(1);
        run_phase(1, 1, 150);
        do_reset(1);
        run_phase(1, 3, 180);

        do_reset(2);
        run_phase(2, 2, 870);

        checks++;
        if (probe_hits != probes.size()) begin
            errors++;
            $display("FAIL probe_coverage got %0d hits exp %0d", probe_hits, probes.size());
        end

        finish_run();
    end

endmodule
